// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data access over req/ack bus with wait states, loads MEM/WB.
// Stalls the front of the pipeline while an aligned load/store is outstanding on the bus.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        em_valid,
  input  logic [1:0]  em_datatoreg,
  input  logic        em_regwrite,
  input  logic        em_mem_w,
  input  logic [31:0] em_result,
  input  logic [31:0] em_rdatab,
  input  logic [4:0]  em_rd,
  input  logic [31:0] em_pc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        mem_stall,
  output logic        mw_valid,
  output logic        mw_regwrite,
  output logic [4:0]  mw_rd,
  output logic [31:0] mw_wdata,
  output logic        mw_bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              bus_req_q, bus_we_q;
  logic [31:0]       bus_addr_q, bus_wdata_q;
  logic              mw_valid_q, mw_regwrite_q, mw_bus_err_q;
  logic [4:0]        mw_rd_q;
  logic [31:0]       mw_wdata_q;

  logic mem_op, misal;

  assign mem_op    = em_valid & (em_mem_w | (em_datatoreg == 2'b01));
  assign misal     = (em_result[1:0] != 2'b00);
  assign mem_stall = (state_q == BUSY) | ((state_q == IDLE) & mem_op & ~misal);

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign mw_valid    = mw_valid_q;
  assign mw_regwrite = mw_regwrite_q;
  assign mw_rd       = mw_rd_q;
  assign mw_wdata    = mw_wdata_q;
  assign mw_bus_err  = mw_bus_err_q;

  function automatic logic [31:0] wb_data(input logic [1:0] sel, input logic [31:0] ld);
    case (sel)
      2'b01:   wb_data = ld;
      2'b10:   wb_data = em_pc + 32'd4;
      default: wb_data = em_result;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      mw_valid_q    <= 1'b0;
      mw_regwrite_q <= 1'b0;
      mw_rd_q       <= '0;
      mw_wdata_q    <= '0;
      mw_bus_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op && !misal) begin
            state_q       <= BUSY;
            bus_req_q     <= 1'b1;
            bus_we_q      <= em_mem_w;
            bus_addr_q    <= {em_result[31:2], 2'b00};
            bus_wdata_q   <= em_rdatab;
            cnt_q         <= '0;
            mw_valid_q    <= 1'b0;
            mw_regwrite_q <= 1'b0;
            mw_bus_err_q  <= 1'b0;
          end else if (mem_op) begin
            // Misaligned access never reaches the bus; retire it as a faulted no-write.
            mw_valid_q    <= 1'b1;
            mw_regwrite_q <= 1'b0;
            mw_rd_q       <= em_rd;
            mw_wdata_q    <= '0;
            mw_bus_err_q  <= 1'b1;
          end else begin
            mw_valid_q    <= em_valid;
            mw_regwrite_q <= em_valid & em_regwrite;
            mw_rd_q       <= em_rd;
            mw_wdata_q    <= wb_data(em_datatoreg, 32'd0);
            mw_bus_err_q  <= 1'b0;
          end
        end
        BUSY: begin
          mw_valid_q    <= 1'b0;
          mw_regwrite_q <= 1'b0;
          mw_bus_err_q  <= 1'b0;
          if (bus_ack) begin
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            rdata_q   <= bus_rdata;
            err_q     <= 1'b0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // EX/MEM advances on this edge, so the access is retired exactly once.
          state_q       <= IDLE;
          mw_valid_q    <= 1'b1;
          mw_regwrite_q <= em_regwrite & ~err_q;
          mw_rd_q       <= em_rd;
          mw_wdata_q    <= wb_data(em_datatoreg, rdata_q);
          mw_bus_err_q  <= err_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage.
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        em_valid, em_regwrite, em_mem_w;
  logic [1:0]  em_datatoreg;
  logic [31:0] em_result, em_rdatab, em_pc;
  logic [4:0]  em_rd;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        mem_stall, mw_valid, mw_regwrite, mw_bus_err;
  logic [4:0]  mw_rd;
  logic [31:0] mw_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .em_valid(em_valid), .em_datatoreg(em_datatoreg), .em_regwrite(em_regwrite),
    .em_mem_w(em_mem_w), .em_result(em_result), .em_rdatab(em_rdatab),
    .em_rd(em_rd), .em_pc(em_pc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .mem_stall(mem_stall),
    .mw_valid(mw_valid), .mw_regwrite(mw_regwrite), .mw_rd(mw_rd),
    .mw_wdata(mw_wdata), .mw_bus_err(mw_bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents one instruction in EX/MEM, holds it while stalled, answers the bus after
  // 'waits' wait states (>= TIMEOUT means never), then checks the MEM/WB result.
  task automatic run_instr(input logic v, input logic [1:0] dtr, input logic rw,
                           input logic mw, input logic [31:0] res, input logic [31:0] wd,
                           input logic [4:0] rd, input logic [31:0] pc, input int waits,
                           input logic [31:0] rdata);
    logic        mem_op, misal, acc, tmo, exp_err, bub_ok, bus_ok, done;
    logic [31:0] ld, exp_wd;
    int          exp_stall, exp_req, stalls, reqs, cyc;

    em_valid = v; em_datatoreg = dtr; em_regwrite = rw; em_mem_w = mw;
    em_result = res; em_rdatab = wd; em_rd = rd; em_pc = pc;

    mem_op  = v & (mw | (dtr == 2'b01));
    misal   = (res[1:0] != 2'b00);
    acc     = mem_op & ~misal;
    tmo     = (waits >= TIMEOUT);
    exp_err = mem_op & (misal | (acc & tmo));
    ld      = (acc && !tmo) ? rdata : 32'd0;
    if (mem_op && misal)    exp_wd = 32'd0;
    else if (dtr == 2'b01)  exp_wd = ld;
    else if (dtr == 2'b10)  exp_wd = pc + 32'd4;
    else                    exp_wd = res;
    exp_stall = !acc ? 0 : (tmo ? TIMEOUT + 1 : waits + 2);
    exp_req   = !acc ? 0 : (tmo ? TIMEOUT : waits + 1);

    stalls = 0; reqs = 0; cyc = 0; bub_ok = 1'b1; bus_ok = 1'b1; done = 1'b0;
    while (!done && cyc < 64) begin
      #1;
      if (cyc > 0 && mw_valid !== 1'b0) bub_ok = 1'b0;
      if (bus_req === 1'b1) begin
        if (bus_we !== mw || bus_addr !== {res[31:2], 2'b00} || bus_wdata !== wd) bus_ok = 1'b0;
        bus_ack   = (reqs == waits);
        bus_rdata = (reqs == waits) ? rdata : $urandom;
        reqs++;
      end else begin
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      if (mem_stall === 1'b1) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    bus_ack = 1'b0;

    check("stall_bound", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    check("req_cycles", 32'(reqs), 32'(exp_req));
    check("bubble", 32'(bub_ok), 32'd1);
    if (exp_req > 0) check("bus_fields", 32'(bus_ok), 32'd1);
    check("mw_valid", 32'(mw_valid), 32'(v));
    check("mw_regwrite", 32'(mw_regwrite), 32'(v & rw & ~exp_err));
    if (v) begin
      check("mw_rd", 32'(mw_rd), 32'(rd));
      check("mw_wdata", mw_wdata, exp_wd);
      check("mw_bus_err", 32'(mw_bus_err), 32'(exp_err));
    end
  endtask

  initial begin
    rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    em_valid = 0; em_datatoreg = 0; em_regwrite = 0; em_mem_w = 0;
    em_result = 0; em_rdatab = 0; em_rd = 0; em_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus", bus_addr | bus_wdata | 32'(bus_we), 32'd0);
    check("rst_mw_valid", 32'(mw_valid), 32'd0);
    check("rst_mw", mw_wdata | 32'(mw_rd) | 32'(mw_regwrite) | 32'(mw_bus_err), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(1, 2'b00, 1, 0, 32'h1234, 32'h0, 5'd5, 32'h0, 0, 32'h0);
    run_instr(1, 2'b01, 1, 0, 32'h100, 32'h0, 5'd7, 32'h10, 1, 32'hDEADBEEF);
    run_instr(1, 2'b00, 0, 1, 32'h40, 32'hA5A5, 5'd3, 32'h14, 0, 32'h0);
    run_instr(1, 2'b01, 1, 0, 32'h200, 32'h0, 5'd9, 32'h18, 100, 32'h0);
    run_instr(1, 2'b01, 1, 0, 32'h102, 32'h0, 5'd4, 32'h1C, 0, 32'h0);
    run_instr(1, 2'b10, 1, 0, 32'h0, 32'h0, 5'd1, 32'hFFFFFFFC, 0, 32'h0);
    run_instr(0, 2'b01, 1, 0, 32'h300, 32'h0, 5'd2, 32'h20, 0, 32'h0);
    run_instr(1, 2'b01, 1, 0, 32'h304, 32'h0, 5'd6, 32'h24, TIMEOUT - 1, 32'hCAFEF00D);
    run_instr(1, 2'b01, 1, 0, 32'h308, 32'h0, 5'd8, 32'h28, 0, 32'h12345678);

    for (int i = 0; i < 60; i++) begin
      logic        v, rw, mw;
      logic [1:0]  dtr;
      logic [31:0] res;
      int          kind, waits;
      v     = ($urandom_range(0, 7) != 0);
      kind  = $urandom_range(0, 3);
      rw    = 1'($urandom_range(0, 1));
      res   = $urandom;
      if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
      mw    = (kind == 2);
      case (kind)
        0:       dtr = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
        1:       dtr = 2'b01;
        2:       dtr = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
        default: dtr = 2'b10;
      endcase
      waits = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 5);
      run_instr(v, dtr, rw, mw, res, $urandom, 5'($urandom), $urandom, waits, $urandom);
    end

    // Reset in the middle of an outstanding access
    em_valid = 1; em_datatoreg = 2'b01; em_regwrite = 1; em_mem_w = 0;
    em_result = 32'h400; em_rd = 5'd11; bus_ack = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("busy_req", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(bus_req), 32'd0);
    check("rst_mid_mw_valid", 32'(mw_valid), 32'd0);
    em_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_stall", 32'(mem_stall), 32'd0);
    check("post_rst_req", 32'(bus_req), 32'd0);
    check("post_rst_mw_valid", 32'(mw_valid), 32'd0);
    run_instr(1, 2'b01, 1, 0, 32'h500, 32'h0, 5'd12, 32'h30, 2, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
